// File: rtl/frame_draw_scheduler_pkg.sv
// Shared screen geometry, pixel bus widths and scheduler state encoding
// for the 160x120 frame-buffer draw path.
package frame_draw_scheduler_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SELECT,
    GRANTED
  } state_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// Requester-side handshake/pixel buses and the arbitrated VGA write port.
// master = scheduler, slave = sprite controllers plus the adapter.
interface frame_draw_scheduler_if #(
  parameter int NUM_REQ = 3
);
  import frame_draw_scheduler_pkg::*;

  logic                         frame;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           done;
  logic [NUM_REQ-1:0]           grant;
  logic [X_W*NUM_REQ-1:0]       req_x;
  logic [Y_W*NUM_REQ-1:0]       req_y;
  logic [COLOUR_W*NUM_REQ-1:0]  req_colour;
  logic [NUM_REQ-1:0]           req_plot;
  logic [X_W-1:0]               vga_x;
  logic [Y_W-1:0]               vga_y;
  logic [COLOUR_W-1:0]          vga_colour;
  logic                         vga_plot;
  logic                         busy;
  logic                         overrun;

  modport master (
    output frame, grant, vga_x, vga_y, vga_colour, vga_plot, busy, overrun,
    input  req, done, req_x, req_y, req_colour, req_plot
  );

  modport slave (
    input  frame, grant, vga_x, vga_y, vga_colour, vga_plot, busy, overrun,
    output req, done, req_x, req_y, req_colour, req_plot
  );

endinterface

// File: rtl/frame_draw_scheduler_fixed_prio_picker.sv
// Combinational lowest-set-bit one-hot selector; bit 0 wins.
module fixed_prio_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] pending,
  output logic [N-1:0] onehot
);

  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pending[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Frame-tick sequencer and fixed-priority arbiter for the single VGA pixel-write port.
// Define FRAME_CLEAR_EN to insert a full-screen BG_COLOUR sweep before each sprite pass.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int                  NUM_REQ   = 3,
  parameter int                  FRAME_DIV = 833333,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 12'h000
) (
  input logic                    clk,
  input logic                    reset,
  frame_draw_scheduler_if.master bus
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                frame_w;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  pick;

  logic [X_W-1:0]      sel_x_p0;
  logic [Y_W-1:0]      sel_y_p0;
  logic [COLOUR_W-1:0] sel_colour_p0;
  logic                sel_plot_p0;

  logic [X_W-1:0]      vga_x_p1;
  logic [Y_W-1:0]      vga_y_p1;
  logic [COLOUR_W-1:0] vga_colour_p1;
  logic                vga_plot_p1;

`ifdef FRAME_CLEAR_EN
  logic [X_W-1:0]      clr_x;
  logic [Y_W-1:0]      clr_y;
`endif

  assign frame_w = (cnt == CNT_W'(FRAME_DIV - 1));

  fixed_prio_picker #(.N(NUM_REQ)) u_picker (
    .pending (pending),
    .onehot  (pick)
  );

  // p0: select the granted requester's pixel slice (grant is one-hot or zero)
  always_comb begin
    sel_x_p0      = '0;
    sel_y_p0      = '0;
    sel_colour_p0 = '0;
    sel_plot_p0   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x_p0      = bus.req_x[i*X_W +: X_W];
        sel_y_p0      = bus.req_y[i*Y_W +: Y_W];
        sel_colour_p0 = bus.req_colour[i*COLOUR_W +: COLOUR_W];
        sel_plot_p0   = bus.req_plot[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= '0;
      grant         <= '0;
      bus.overrun   <= 1'b0;
      vga_x_p1      <= '0;
      vga_y_p1      <= '0;
      vga_colour_p1 <= '0;
      vga_plot_p1   <= 1'b0;
`ifdef FRAME_CLEAR_EN
      clr_x         <= '0;
      clr_y         <= '0;
`endif
    end else begin
      cnt <= frame_w ? '0 : cnt + CNT_W'(1);

      // A tick arriving mid-schedule is dropped, only flagged
      if (frame_w && state != IDLE)
        bus.overrun <= 1'b1;

      // p1: registered write port; x/y/colour hold while nobody owns it
      vga_plot_p1 <= 1'b0;
      if (|grant) begin
        vga_x_p1      <= sel_x_p0;
        vga_y_p1      <= sel_y_p0;
        vga_colour_p1 <= sel_colour_p0;
        vga_plot_p1   <= sel_plot_p0;
      end

      case (state)
        IDLE: begin
          if (frame_w) begin
            pending <= bus.req;
`ifdef FRAME_CLEAR_EN
            clr_x   <= '0;
            clr_y   <= '0;
            state   <= CLEAR;
`else
            state   <= SELECT;
`endif
          end
        end
`ifdef FRAME_CLEAR_EN
        CLEAR: begin
          vga_x_p1      <= clr_x;
          vga_y_p1      <= clr_y;
          vga_colour_p1 <= BG_COLOUR;
          vga_plot_p1   <= 1'b1;
          if (clr_x == X_W'(SCREEN_W - 1)) begin
            clr_x <= '0;
            if (clr_y == Y_W'(SCREEN_H - 1)) begin
              clr_y <= '0;
              state <= SELECT;
            end else begin
              clr_y <= clr_y + Y_W'(1);
            end
          end else begin
            clr_x <= clr_x + X_W'(1);
          end
        end
`endif
        SELECT: begin
          if (pending == '0) begin
            state <= IDLE;
          end else begin
            grant   <= pick;
            pending <= pending & ~pick;
            state   <= GRANTED;
          end
        end
        GRANTED: begin
          if (|(bus.done & grant)) begin
            grant <= '0;
            state <= SELECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame      = frame_w;
  assign bus.grant      = grant;
  assign bus.busy       = (state != IDLE);
  assign bus.vga_x      = vga_x_p1;
  assign bus.vga_y      = vga_y_p1;
  assign bus.vga_colour = vga_colour_p1;
  assign bus.vga_plot   = vga_plot_p1;

endmodule
